// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with a two-stage
// output pipeline, border colour and frame-boundary run/stop control.
//
// Ports:
//   vga_clk        pixel clock
//   sys_rst        synchronous reset, active-high
//   en             run request, acted on only at a frame boundary
//   pix_data       upstream pixel, valid the cycle after pix_req
//   border_color   colour shown in the border region
//   pix_req        combinational request, high in the active region
//   pix_x, pix_y   active coordinates while pix_req, else 0
//   rgb            registered pixel output
//   hsync, vsync   registered syncs with programmable polarity
//   de             registered data enable (active or border)
//   frame_start    one-cycle pulse on the first output cycle of a frame
//   busy           high while a frame is being scanned
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 40,
  parameter int H_LEFT  = 8,
  parameter int H_VALID = 640,
  parameter int H_RIGHT = 8,
  parameter int H_FRONT = 8,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 25,
  parameter int V_LEFT  = 8,
  parameter int V_VALID = 480,
  parameter int V_RIGHT = 8,
  parameter int V_FRONT = 2,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int CW      = 12,
  parameter int DW      = 16
) (
  input  logic          vga_clk,
  input  logic          sys_rst,
  input  logic          en,
  input  logic [DW-1:0] pix_data,
  input  logic [DW-1:0] border_color,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [DW-1:0] rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic          busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_LEFT + V_VALID + V_RIGHT + V_FRONT;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  // visible window (border + active)
  localparam logic [CW-1:0] HB0 = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] HB1 = CW'(H_TOTAL - H_FRONT);
  localparam logic [CW-1:0] VB0 = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VB1 = CW'(V_TOTAL - V_FRONT);
  // active window
  localparam logic [CW-1:0] HA0 = CW'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [CW-1:0] HA1 = CW'(H_SYNC + H_BACK + H_LEFT + H_VALID);
  localparam logic [CW-1:0] VA0 = CW'(V_SYNC + V_BACK + V_LEFT);
  localparam logic [CW-1:0] VA1 = CW'(V_SYNC + V_BACK + V_LEFT + V_VALID);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;

  // stage 1: region flags of the counter state
  logic s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic s1_act_q, s1_act_d, s1_brd_q, s1_brd_d, s1_first_q, s1_first_d;

  // stage 2: pins
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [DW-1:0] rgb_q, rgb_d;

  logic run, h_last, v_last, h_act, v_act, h_vis, v_vis;

  assign run    = (state_q == RUN);
  assign h_last = (cnt_h_q == H_LAST);
  assign v_last = (cnt_v_q == V_LAST);
  assign h_act  = (cnt_h_q >= HA0) && (cnt_h_q < HA1);
  assign v_act  = (cnt_v_q >= VA0) && (cnt_v_q < VA1);
  assign h_vis  = (cnt_h_q >= HB0) && (cnt_h_q < HB1);
  assign v_vis  = (cnt_v_q >= VB0) && (cnt_v_q < VB1);

  // Run control and raster counters. Stopping is only possible on the last
  // pixel of a frame, so dropping en mid-frame lets the frame finish.
  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    case (state_q)
      IDLE: begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        if (en) state_d = RUN;
      end
      default: begin
        if (h_last) begin
          cnt_h_d = '0;
          if (v_last) begin
            cnt_v_d = '0;
            if (!en) state_d = IDLE;
          end else begin
            cnt_v_d = cnt_v_q + ONE;
          end
        end else begin
          cnt_h_d = cnt_h_q + ONE;
        end
      end
    endcase
  end

  // Stage 0 request, one cycle ahead of the data it asks for.
  always_comb begin
    pix_req = run && h_act && v_act;
    pix_x   = pix_req ? (cnt_h_q - HA0) : '0;
    pix_y   = pix_req ? (cnt_v_q - VA0) : '0;
  end

  // Flags are gated with run so the pipeline drains to idle levels after a stop.
  always_comb begin
    s1_hs_d    = run && (cnt_h_q < HS_END);
    s1_vs_d    = run && (cnt_v_q < VS_END);
    s1_act_d   = pix_req;
    s1_brd_d   = run && h_vis && v_vis && !pix_req;
    s1_first_d = run && (cnt_h_q == '0) && (cnt_v_q == '0);
  end

  // Stage 2: pix_data arrives this cycle for the request made one cycle ago.
  always_comb begin
    hsync_d = s1_hs_q ? HS_POL : ~HS_POL;
    vsync_d = s1_vs_q ? VS_POL : ~VS_POL;
    de_d    = s1_act_q || s1_brd_q;
    fs_d    = s1_first_q;
    rgb_d   = '0;
    if (s1_act_q)      rgb_d = pix_data;
    else if (s1_brd_q) rgb_d = border_color;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_h_q    <= '0;
      cnt_v_q    <= '0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_act_q   <= 1'b0;
      s1_brd_q   <= 1'b0;
      s1_first_q <= 1'b0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_h_q    <= cnt_h_d;
      cnt_v_q    <= cnt_v_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_act_q   <= s1_act_d;
      s1_brd_q   <= s1_brd_d;
      s1_first_q <= s1_first_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
      rgb_q      <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign busy        = run;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster. A frame-position
// reference model predicts pins (2-cycle delayed), pix_req/pix_x/pix_y and busy.
module tb_vga_timing_gen;
  localparam int HS = 3, HB = 2, HL = 2, HV = 6, HR = 2, HF = 3;
  localparam int VS = 2, VB = 1, VL = 2, VV = 4, VR = 1, VF = 2;
  localparam int HT = HS + HB + HL + HV + HR + HF;
  localparam int VT = VS + VB + VL + VV + VR + VF;
  localparam int HA0 = HS + HB + HL;
  localparam int VA0 = VS + VB + VL;
  localparam int CW = 12, DW = 16;
  localparam bit HP = 1'b0, VP = 1'b1;

  logic          vga_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [DW-1:0] border_color = '0;
  logic          pix_req, hsync, vsync, de, frame_start, busy;
  logic [CW-1:0] pix_x, pix_y;
  logic [DW-1:0] rgb;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_LEFT(VL), .V_VALID(VV), .V_RIGHT(VR), .V_FRONT(VF),
    .HS_POL(HP), .VS_POL(VP), .CW(CW), .DW(DW)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .en(en), .pix_data(pix_data),
    .border_color(border_color), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
    .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  // upstream source with one registered cycle of latency
  always @(posedge vga_clk) pix_data <= {pix_y[7:0], pix_x[7:0]};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_act(int h, int v);
    return h >= HA0 && h < HA0 + HV && v >= VA0 && v < VA0 + VV;
  endfunction

  function automatic bit is_brd(int h, int v);
    return !is_act(h, v) && h >= HS + HB && h < HT - HF && v >= VS + VB && v < VT - VF;
  endfunction

  // model: m_run/m_pos = current scan state; d_* = scan state one cycle older
  int m_run = 0, m_pos = 0;
  int d_run = 0, d_h = 0, d_v = 0;
  logic          e_hs, e_vs, e_de, e_fs;
  logic [DW-1:0] e_rgb;
  int            fs_seen = 0;

  always @(posedge vga_clk) begin
    logic          r, e;
    logic [DW-1:0] bc;
    logic [7:0]    ex, ey;
    int            h, v;
    r = sys_rst; e = en; bc = border_color;
    if (r) begin
      e_hs = ~HP; e_vs = ~VP; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0;
      d_run = 0; d_h = 0; d_v = 0;
      m_run = 0; m_pos = 0;
    end else begin
      e_hs  = (d_run != 0 && d_h < HS) ? HP : ~HP;
      e_vs  = (d_run != 0 && d_v < VS) ? VP : ~VP;
      e_fs  = d_run != 0 && d_h == 0 && d_v == 0;
      e_de  = d_run != 0 && (is_act(d_h, d_v) || is_brd(d_h, d_v));
      ex    = 8'(d_h - HA0);
      ey    = 8'(d_v - VA0);
      e_rgb = '0;
      if (d_run != 0 && is_act(d_h, d_v))      e_rgb = {ey, ex};
      else if (d_run != 0 && is_brd(d_h, d_v)) e_rgb = bc;
      d_run = m_run; d_h = m_pos % HT; d_v = m_pos / HT;
      if (m_run == 0) begin
        m_run = e ? 1 : 0;
        m_pos = 0;
      end else if (m_pos == HT * VT - 1) begin
        m_run = e ? 1 : 0;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    #1;
    h = m_pos % HT; v = m_pos / HT;
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("de", de, e_de);
    chk("rgb", rgb, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("busy", busy, m_run != 0);
    chk("pix_req", pix_req, m_run != 0 && is_act(h, v));
    chk("pix_x", pix_x, (m_run != 0 && is_act(h, v)) ? h - HA0 : 0);
    chk("pix_y", pix_y, (m_run != 0 && is_act(h, v)) ? v - VA0 : 0);
    if (frame_start) fs_seen++;
  end

  initial begin
    sys_rst = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge vga_clk);
    // idle stretch with en low
    sys_rst = 1'b0;
    en = 1'b0;
    repeat (300) @(negedge vga_clk);
    en = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge vga_clk);
      border_color = DW'($urandom);
      if (en) begin
        if ($urandom_range(0, 399) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 49) == 0) en = 1'b1;
      end
      sys_rst = ($urandom_range(0, 1499) == 0);
    end
    sys_rst = 1'b0;
    en = 1'b1;
    repeat (3 * HT * VT) @(negedge vga_clk);
    @(negedge vga_clk);
    chk("frames_seen", fs_seen > 20, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
